saes_key_sched: RTL and testbench

Sequential S-AES key scheduler. It expands a 16-bit cipher key into round keys K0/K1/K2 using one time-shared `nibble_substitution` instance over two cycles, then holds the keys in registers. A combinational round-indexed read port serves the round controller in both encrypt and decrypt order. It replaces the purely combinational expansion, which needs two S-box pairs, wherever area matters. It also skips recomputation when the same key is presented again.

---
 rtl/saes_pkg.sv | 19 +
 rtl/nibble_substitution.sv | 34 +++
 rtl/saes_key_sched.sv | 107 ++++++++++
 tb/tb_saes_key_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/saes_pkg.sv
// Shared S-AES key-schedule definitions: round constants, FSM states and
// the nibble rotation used ahead of the S-box.
package saes_pkg;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXP1  = 2'd1,
    EXP2  = 2'd2,
    READY = 2'd3
  } state_e;

  function automatic logic [7:0] rot_nib(input logic [7:0] w);
    return {w[3:0], w[7:4]};
  endfunction

endpackage

// File: rtl/nibble_substitution.sv
// S-AES byte substitution: two independent 4-bit S-box lookups, forward
// when Encrypt=1 and inverse when Encrypt=0.
module nibble_substitution (
  input  logic       Encrypt,
  input  logic [7:0] In,
  output logic [7:0] Out
);

  function automatic logic [3:0] sbox(input logic enc, input logic [3:0] n);
    logic [3:0] r;
    r = '0;
    if (enc) begin
      case (n)
        4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
        4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
        4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
        4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
      endcase
    end else begin
      case (n)
        4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
        4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
        4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
        4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    Out = {sbox(Encrypt, In[7:4]), sbox(Encrypt, In[3:0])};
  end

endmodule

// File: rtl/saes_key_sched.sv
// Sequential S-AES key scheduler: one shared S-box expands K1 then K2 over
// two cycles; keys are held in registers behind a round-indexed read port.
module saes_key_sched
  import saes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [15:0] key_in,
  output logic        keys_valid,
  output logic        busy,
  input  logic        encrypt,
  input  logic [1:0]  rnd,
  output logic [15:0] rk
);

  state_e      state_q;
  logic [15:0] k0_q, k1_q, k2_q;
  logic        key_ready_q, keys_valid_q, busy_q;

  logic [7:0]  w_hi_src, w_lo_src, rcon;
  logic [7:0]  sbox_in, sbox_out;
  logic [15:0] kx_d;
  logic [1:0]  idx;
  logic        miss;

  // Both expansion steps share one datapath: EXP1 works on (w0,w1), EXP2 on (w2,w3).
  always_comb begin
    w_hi_src = k1_q[15:8];
    w_lo_src = k1_q[7:0];
    rcon     = RCON2;
    if (state_q == EXP1) begin
      w_hi_src = k0_q[15:8];
      w_lo_src = k0_q[7:0];
      rcon     = RCON1;
    end
    sbox_in    = rot_nib(w_lo_src);
    kx_d[15:8] = w_hi_src ^ rcon ^ sbox_out;
    kx_d[7:0]  = kx_d[15:8] ^ w_lo_src;
  end

  nibble_substitution u_sbox (
    .Encrypt (1'b1),
    .In      (sbox_in),
    .Out     (sbox_out)
  );

  assign miss = key_valid && ((state_q == IDLE) || (key_in != k0_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k0_q         <= '0;
      k1_q         <= '0;
      k2_q         <= '0;
      key_ready_q  <= 1'b1;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (miss) begin
            k0_q         <= key_in;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= EXP1;
          end
        end
        EXP1: begin
          k1_q    <= kx_d;
          state_q <= EXP2;
        end
        EXP2: begin
          k2_q         <= kx_d;
          keys_valid_q <= 1'b1;
          key_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= READY;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign key_ready  = key_ready_q;
  assign keys_valid = keys_valid_q;
  assign busy       = busy_q;

  // Decrypt order walks the schedule backwards; rnd=3 is out of range in both orders.
  always_comb begin
    idx = encrypt ? rnd : (2'd2 - rnd);
    rk  = '0;
    if (rnd != 2'd3) begin
      case (idx)
        2'd0:    rk = k0_q;
        2'd1:    rk = k1_q;
        2'd2:    rk = k2_q;
        default: rk = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_saes_key_sched.sv
// Scoreboard bench for saes_key_sched: stimulus queues expected schedules,
// a monitor compares them whenever keys_valid rises or reset is released.
module tb_saes_key_sched;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_in;
  logic        keys_valid;
  logic        busy;
  logic        encrypt;
  logic [1:0]  rnd;
  logic [15:0] rk;

  typedef struct {
    bit          is_rst;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  logic prev_kv  = 1'b0;
  logic prev_rst = 1'b0;

  saes_key_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .keys_valid (keys_valid),
    .busy       (busy),
    .encrypt    (encrypt),
    .rnd        (rnd),
    .rk         (rk)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] n);
    case (n)
      4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
      4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
      4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h7;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] k);
    exp_t e;
    logic [7:0] w0, w1, w2, w3, w4, w5;
    w0 = k[15:8];
    w1 = k[7:0];
    w2 = w0 ^ 8'h80 ^ {sb(w1[3:0]), sb(w1[7:4])};
    w3 = w1 ^ w2;
    w4 = w2 ^ 8'h30 ^ {sb(w3[3:0]), sb(w3[7:4])};
    w5 = w4 ^ w3;
    e.is_rst = 1'b0;
    e.k0 = k;
    e.k1 = {w2, w3};
    e.k2 = {w4, w5};
    return e;
  endfunction

  // Monitor: owns rnd/encrypt and sweeps the read port when a result appears.
  task automatic sweep(input exp_t e);
    logic        enc_v[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  rnd_v[8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [15:0] req_v[8];
    req_v = '{e.k0, e.k1, e.k2, e.k2, e.k1, e.k0, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      encrypt = enc_v[i];
      rnd     = rnd_v[i];
      #1;
      check($sformatf("rk enc=%0d rnd=%0d key=%h", enc_v[i], rnd_v[i], e.k0), rk, req_v[i]);
    end
    encrypt = 1'b1;
    rnd     = 2'd0;
  endtask

  initial begin
    exp_t e;
    encrypt = 1'b1;
    rnd     = 2'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && !prev_rst) begin
        n_checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_rst) begin
          n_errs++;
          $display("FAIL reset_release: no reset expectation queued (t=%0t)", $time);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          check("reset keys_valid", {15'd0, keys_valid}, 16'd0);
          check("reset busy", {15'd0, busy}, 16'd0);
          check("reset key_ready", {15'd0, key_ready}, 16'd1);
          sweep(e);
        end
      end else if (keys_valid && !prev_kv) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].is_rst) begin
          n_errs++;
          $display("FAIL keys_valid_rise: unexpected schedule, K0=%h (t=%0t)", dut.k0_q, $time);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          check("done busy", {15'd0, busy}, 16'd0);
          check("done key_ready", {15'd0, key_ready}, 16'd1);
          sweep(e);
        end
      end
      prev_kv  = keys_valid;
      prev_rst = rst_n;
    end
  end

  initial begin
    #2_000_000;
    n_errs++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Stimulus: all inputs change on the falling edge.
  initial begin
    exp_t e;
    logic [15:0] k, prev_k;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    e.is_rst = 1'b1; e.k0 = '0; e.k1 = '0; e.k2 = '0;
    exp_q.push_back(e);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("post-reset key_ready", {15'd0, key_ready}, 16'd1);
    @(negedge clk);

    // A73B from IDLE with latency checks
    e.is_rst = 1'b0; e.k0 = 16'hA73B; e.k1 = 16'h1C27; e.k2 = 16'h7651;
    exp_q.push_back(e);
    key_valid = 1'b1; key_in = 16'hA73B;
    @(negedge clk);
    key_valid = 1'b0;
    check("N busy", {15'd0, busy}, 16'd1);
    check("N key_ready", {15'd0, key_ready}, 16'd0);
    check("N keys_valid", {15'd0, keys_valid}, 16'd0);
    @(negedge clk);
    check("N+1 keys_valid", {15'd0, keys_valid}, 16'd0);
    check("N+1 busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check("N+2 keys_valid", {15'd0, keys_valid}, 16'd1);
    @(negedge clk);

    // hit: same key again
    key_valid = 1'b1; key_in = 16'hA73B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hit keys_valid", {15'd0, keys_valid}, 16'd1);
      check("hit busy", {15'd0, busy}, 16'd0);
      check("hit rk", rk, 16'hA73B);
    end
    key_valid = 1'b0;
    @(negedge clk);

    // miss from READY with key 0000
    e.k0 = 16'h0000; e.k1 = 16'h1919; e.k2 = 16'h0D14;
    exp_q.push_back(e);
    key_valid = 1'b1; key_in = 16'h0000;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);

    // key_valid pulse during EXP1 must be ignored
    e.k0 = 16'hA73B; e.k1 = 16'h1C27; e.k2 = 16'h7651;
    exp_q.push_back(e);
    key_valid = 1'b1; key_in = 16'hA73B;
    @(negedge clk);
    key_in = 16'h0000;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("after ignored pulse busy", {15'd0, busy}, 16'd0);
    check("after ignored pulse keys_valid", {15'd0, keys_valid}, 16'd1);

    // reset in the middle of EXP2
    e.is_rst = 1'b1; e.k0 = '0; e.k1 = '0; e.k2 = '0;
    exp_q.push_back(e);
    key_valid = 1'b1; key_in = 16'h0000;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check("EXP2 busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-reset key_ready", {15'd0, key_ready}, 16'd1);
    check("mid-reset keys_valid", {15'd0, keys_valid}, 16'd0);
    @(negedge clk);

    // 1000 random keys at the earliest accept edges
    prev_k = 16'h0000;
    for (int n = 0; n < 1000; n++) begin
      do k = 16'($urandom); while (k == prev_k);
      prev_k = k;
      exp_q.push_back(model(k));
      check("rand key_ready", {15'd0, key_ready}, 16'd1);
      key_valid = 1'b1; key_in = k;
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
